// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA CRT decrypt engine and its exponentiation core.
package rsa_pkg;

   localparam int WORD_WIDTH_DEFAULT = 32;
   // The half-width datapath always carries p, q, dp, dq and qinv.
   localparam int HALF_WIDTH_DEFAULT = WORD_WIDTH_DEFAULT / 2;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EXP_P,
      ST_WAIT_P,
      ST_EXP_Q,
      ST_WAIT_Q,
      ST_SUB,
      ST_MULH,
      ST_RECOMB,
      ST_DONE
   } crt_state_t;

   typedef enum logic [2:0] {
      EXP_R2,
      EXP_XBAR,
      EXP_SQR,
      EXP_MUL,
      EXP_FIN,
      EXP_DONE
   } exp_state_t;

   // Index of the highest set bit; 0 for a zero exponent.
   function automatic logic [4:0] msb_index(input logic [HALF_WIDTH_DEFAULT-1:0] e);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < HALF_WIDTH_DEFAULT; i++) begin
         if (e[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/montgomery_exp.sv
// Left-to-right modular exponentiation x^e mod m (m odd) using bit-serial Montgomery
// multiplication with R = 2^WORD_WIDTH; R^2 mod m is derived on the fly by doubling.
module montgomery_exp
   import rsa_pkg::*;
#(
   parameter int WORD_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [WORD_WIDTH-1:0] m,
   input  logic [WORD_WIDTH-1:0] x,
   input  logic [WORD_WIDTH-1:0] e,
   input  logic [4:0]            t,
   output logic                  done,
   output logic [WORD_WIDTH-1:0] exp_result
);

   localparam int W  = WORD_WIDTH;
   localparam int CW = $clog2(2 * W) + 1;

   exp_state_t    state, state_d;
   logic [W-1:0]  r, one_m, xbar, acc;
   logic [W+1:0]  s;
   logic [CW-1:0] cnt;
   logic [4:0]    bit_i;

   logic [W-1:0]  mont_a, mont_b, mont_res, dbl_res;
   logic [W+1:0]  t1, t2, s_next, red;
   logic [W:0]    dbl;
   logic          a_bit, e_bit, last;

   always_comb begin
      mont_a = '0;
      mont_b = '0;
      case (state)
         EXP_XBAR: begin mont_a = x;   mont_b = r;    end
         EXP_SQR:  begin mont_a = acc; mont_b = acc;  end
         EXP_MUL:  begin mont_a = acc; mont_b = xbar; end
         EXP_FIN:  begin mont_a = acc; mont_b = W'(1); end
         default:  ;
      endcase
      a_bit    = |(mont_a & (W'(1) << cnt));
      t1       = s + (a_bit ? {2'b00, mont_b} : '0);
      t2       = t1[0] ? t1 + {2'b00, m} : t1;
      s_next   = t2 >> 1;
      red      = (s_next >= {2'b00, m}) ? s_next - {2'b00, m} : s_next;
      mont_res = W'(red);
      dbl      = {r, 1'b0};
      dbl_res  = (dbl >= {1'b0, m}) ? W'(dbl - {1'b0, m}) : W'(dbl);
      e_bit    = |(e & (W'(1) << bit_i));
      last     = (cnt == CW'(W - 1));
   end

   always_comb begin
      state_d = state;
      done    = 1'b0;
      case (state)
         EXP_R2:   if (enable && cnt == CW'(2 * W - 1)) state_d = EXP_XBAR;
         EXP_XBAR: if (enable && last) state_d = EXP_SQR;
         EXP_SQR:  if (enable && last) state_d = e_bit ? EXP_MUL : (bit_i == '0 ? EXP_FIN : EXP_SQR);
         EXP_MUL:  if (enable && last) state_d = (bit_i == '0) ? EXP_FIN : EXP_SQR;
         EXP_FIN:  if (enable && last) state_d = EXP_DONE;
         EXP_DONE: done = 1'b1;
         default:  state_d = EXP_R2;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= EXP_R2;
      else       state <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r          <= W'(1);
         one_m      <= '0;
         xbar       <= '0;
         acc        <= '0;
         s          <= '0;
         cnt        <= '0;
         bit_i      <= '0;
         exp_result <= '0;
      end else if (enable) begin
         case (state)
            EXP_R2: begin
               r <= dbl_res;
               // After W doublings r holds R mod m, the Montgomery form of 1.
               if (cnt == CW'(W - 1)) one_m <= dbl_res;
               cnt <= (cnt == CW'(2 * W - 1)) ? '0 : cnt + CW'(1);
            end
            EXP_XBAR, EXP_SQR, EXP_MUL, EXP_FIN: begin
               s   <= last ? '0 : s_next;
               cnt <= last ? '0 : cnt + CW'(1);
               if (last) begin
                  case (state)
                     EXP_XBAR: begin
                        xbar  <= mont_res;
                        acc   <= one_m;
                        bit_i <= t;
                     end
                     EXP_SQR: begin
                        acc <= mont_res;
                        if (!e_bit && bit_i != '0) bit_i <= bit_i - 5'd1;
                     end
                     EXP_MUL: begin
                        acc <= mont_res;
                        if (bit_i != '0) bit_i <= bit_i - 5'd1;
                     end
                     default: exp_result <= mont_res;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/rsa_crt_decrypt.sv
// RSA CRT decrypt: two half-width exponentiations on one shared core, then Garner recombination.
// Optional operand checking is compiled in with RSA_CRT_CHECK_EN.
module rsa_crt_decrypt
   import rsa_pkg::*;
#(
   parameter int WORD_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [WORD_WIDTH-1:0]   c,
   input  logic [WORD_WIDTH/2-1:0] p,
   input  logic [WORD_WIDTH/2-1:0] q,
   input  logic [WORD_WIDTH/2-1:0] dp,
   input  logic [WORD_WIDTH/2-1:0] dq,
   input  logic [WORD_WIDTH/2-1:0] qinv,
   output logic                    busy,
   output logic                    done,
   output logic [WORD_WIDTH-1:0]   msg,
   output logic                    err
);

   localparam int HALF_WIDTH = WORD_WIDTH / 2;
   localparam int KW         = $clog2(HALF_WIDTH);

   crt_state_t state, state_d;

   logic [WORD_WIDTH-1:0] c_r;
   logic [HALF_WIDTH-1:0] p_r, q_r, dp_r, dq_r, qinv_r;
   logic [HALF_WIDTH-1:0] cp, cq, m1, m2, a, acc;
   logic [4:0]            tp, tq;
   logic [KW-1:0]         k;

   logic                  sel_q, sub_rst, sub_en, sub_done;
   logic [HALF_WIDTH-1:0] sub_m, sub_x, sub_e, sub_result;
   logic [4:0]            sub_t;

   logic [HALF_WIDTH-1:0] m2p, a_next, dbl_red, mulh_next;
   logic [HALF_WIDTH:0]   diff, dbl, add;
   logic                  q_bit;
   logic [WORD_WIDTH-1:0] recomb;

`ifdef RSA_CRT_CHECK_EN
   logic err_cond;
`endif

   // The shared core sees the p operands in the p phase and the q operands in the q phase.
   assign sel_q   = (state == ST_EXP_Q) || (state == ST_WAIT_Q);
   assign sub_m   = sel_q ? q_r  : p_r;
   assign sub_x   = sel_q ? cq   : cp;
   assign sub_e   = sel_q ? dq_r : dp_r;
   assign sub_t   = sel_q ? tq   : tp;
   assign sub_rst = ~reset | (state == ST_EXP_P) | (state == ST_EXP_Q);
   assign sub_en  = (state == ST_WAIT_P) || (state == ST_WAIT_Q);

   montgomery_exp #(
      .WORD_WIDTH (HALF_WIDTH)
   ) u_exp (
      .clk        (clk),
      .reset      (sub_rst),
      .enable     (sub_en),
      .m          (sub_m),
      .x          (sub_x),
      .e          (sub_e),
      .t          (sub_t),
      .done       (sub_done),
      .exp_result (sub_result)
   );

   always_comb begin
      m2p       = m2 % p_r;
      diff      = {1'b0, m1} + {1'b0, p_r} - {1'b0, m2p};
      a_next    = (diff >= {1'b0, p_r}) ? HALF_WIDTH'(diff - {1'b0, p_r}) : HALF_WIDTH'(diff);
      // Interleaved h = qinv * a mod p, MSB of qinv first.
      dbl       = {acc, 1'b0};
      dbl_red   = (dbl >= {1'b0, p_r}) ? HALF_WIDTH'(dbl - {1'b0, p_r}) : HALF_WIDTH'(dbl);
      add       = {1'b0, dbl_red} + {1'b0, a};
      q_bit     = |(qinv_r & (HALF_WIDTH'(1) << k));
      mulh_next = !q_bit ? dbl_red :
                  (add >= {1'b0, p_r}) ? HALF_WIDTH'(add - {1'b0, p_r}) : HALF_WIDTH'(add);
      recomb    = WORD_WIDTH'(acc) * WORD_WIDTH'(q_r) + WORD_WIDTH'(m2);
   end

   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE:   if (start) state_d = ST_LOAD;
`ifdef RSA_CRT_CHECK_EN
         ST_LOAD:   state_d = err_cond ? ST_DONE : ST_EXP_P;
`else
         ST_LOAD:   state_d = ST_EXP_P;
`endif
         ST_EXP_P:  state_d = ST_WAIT_P;
         ST_WAIT_P: if (sub_done) state_d = ST_EXP_Q;
         ST_EXP_Q:  state_d = ST_WAIT_Q;
         ST_WAIT_Q: if (sub_done) state_d = ST_SUB;
         ST_SUB:    state_d = ST_MULH;
         ST_MULH:   if (k == '0) state_d = ST_RECOMB;
         ST_RECOMB: state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_d;
   end

   assign done = (state == ST_DONE);
`ifdef RSA_CRT_CHECK_EN
   assign err  = (state == ST_DONE) && err_cond;
`else
   assign err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         busy   <= 1'b0;
         msg    <= '0;
         c_r    <= '0;
         p_r    <= '0;
         q_r    <= '0;
         dp_r   <= '0;
         dq_r   <= '0;
         qinv_r <= '0;
         cp     <= '0;
         cq     <= '0;
         m1     <= '0;
         m2     <= '0;
         a      <= '0;
         acc    <= '0;
         tp     <= '0;
         tq     <= '0;
         k      <= '0;
`ifdef RSA_CRT_CHECK_EN
         err_cond <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               c_r    <= c;
               p_r    <= p;
               q_r    <= q;
               dp_r   <= dp;
               dq_r   <= dq;
               qinv_r <= qinv;
               busy   <= 1'b1;
`ifdef RSA_CRT_CHECK_EN
               err_cond <= ~p[0] | ~q[0] | (c >= WORD_WIDTH'(p) * WORD_WIDTH'(q));
`endif
            end
            ST_LOAD: begin
               cp <= HALF_WIDTH'(c_r % WORD_WIDTH'(p_r));
               cq <= HALF_WIDTH'(c_r % WORD_WIDTH'(q_r));
               tp <= msb_index(dp_r);
               tq <= msb_index(dq_r);
`ifdef RSA_CRT_CHECK_EN
               if (err_cond) msg <= '0;
`endif
            end
            ST_WAIT_P: if (sub_done) m1 <= sub_result;
            ST_WAIT_Q: if (sub_done) m2 <= sub_result;
            ST_SUB: begin
               a   <= a_next;
               acc <= '0;
               k   <= KW'(HALF_WIDTH - 1);
            end
            ST_MULH: begin
               acc <= mulh_next;
               k   <= k - KW'(1);
            end
            ST_RECOMB: msg  <= recomb;
            ST_DONE:   busy <= 1'b0;
            default:   ;
         endcase
      end
   end

endmodule
